// File: rtl/defines.sv
// rtl/defines.sv - shared frame types for the transmit path
package defines;

    typedef struct packed {
        logic [5:0][7:0] dst;
        logic [5:0][7:0] src;
    } address;

    typedef logic [1:0][7:0] byte_count_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DRAIN  = 2'd3
    } arb_state_t;

    // Byte 1 is the most significant byte of the count.
    function automatic logic [15:0] bc_to_u16(input byte_count_t bc);
        return {bc[1], bc[0]};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_valid
);

    localparam int IW = $clog2(N_REQ);

    // Walk offsets from farthest to nearest so the nearest pending request wins.
    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N_REQ;
            if (req[j]) begin
                grant       = '0;
                grant[j]    = 1'b1;
                grant_idx   = IW'(j);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - shares one transmitter between N_REQ frame requesters
module tx_frame_arbiter
    import defines::*;
#(
    parameter int N_REQ         = 4,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int MAX_LEN       = 1500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  address [N_REQ-1:0]         req_addr,
    input  byte_count_t [N_REQ-1:0]    req_len,
    input  logic [N_REQ-1:0][7:0]      req_data,
    input  logic [N_REQ-1:0]           req_data_valid,
    output logic [N_REQ-1:0]           req_data_ready,
    output logic [N_REQ-1:0]           req_done,
    output logic [N_REQ-1:0]           req_err,
    output address                     header_addr,
    output byte_count_t                number_of_bytes,
    output logic                       rx_header_valid,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       btx_full,
    input  logic                       tx_axis_tvalid,
    input  logic                       tx_axis_tready,
    input  logic                       tx_axis_tlast,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_SAT  = TW'(DRAIN_TIMEOUT);

    arb_state_t state, state_next;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant;
    logic [15:0]      count;
    logic [TW-1:0]    tmo_cnt;

    logic [N_REQ-1:0] arb_onehot;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;

    logic             grant_accept;
    logic             grant_reject;
    logic             finish_ok;
    logic             finish_err;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (arb_onehot),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] g);
        return (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
    endfunction

    logic [15:0] win_len;
    logic        win_reject;
    logic [15:0] frame_len;
    logic        data_hs;
    logic        last_byte;
    logic        axis_last;
    logic        tmo_hit;

    assign win_len    = bc_to_u16(req_len[arb_idx]);
    assign win_reject = (win_len == 16'd0) || (win_len > 16'(MAX_LEN));
    assign frame_len  = bc_to_u16(number_of_bytes);
    assign data_hs    = (state == DATA) && tx_valid;
    assign last_byte  = data_hs && (count == frame_len - 16'd1);
    assign axis_last  = tx_axis_tvalid & tx_axis_tready & tx_axis_tlast;
    assign tmo_hit    = (state == DRAIN) && (tmo_cnt >= TMO_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        grant_accept = 1'b0;
        grant_reject = 1'b0;
        finish_ok    = 1'b0;
        finish_err   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    if (win_reject) begin
                        grant_reject = 1'b1;
                    end else begin
                        grant_accept = 1'b1;
                        state_next   = HEADER;
                    end
                end
            end
            HEADER: state_next = DATA;
            DATA: begin
                if (last_byte) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // A tlast beat on the timeout cycle still counts as a clean finish.
                if (axis_last) begin
                    finish_ok  = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    finish_err = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload path is a zero-latency pass-through from the granted port.
    always_comb begin
        req_data_ready = '0;
        tx_valid       = 1'b0;
        tx_data        = '0;
        if (state == DATA) begin
            req_data_ready[grant] = !btx_full;
            tx_valid              = req_data_valid[grant] & !btx_full;
            tx_data               = req_data[grant];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            grant           <= '0;
            count           <= '0;
            tmo_cnt         <= '0;
            header_addr     <= '0;
            number_of_bytes <= '0;
            rx_header_valid <= 1'b0;
            req_done        <= '0;
            req_err         <= '0;
        end else begin
            rx_header_valid <= 1'b0;
            req_done        <= '0;
            req_err         <= '0;

            if (state == IDLE && arb_valid) begin
                header_addr     <= req_addr[arb_idx];
                number_of_bytes <= req_len[arb_idx];
                grant           <= arb_idx;
            end
            if (grant_accept) begin
                rx_header_valid <= 1'b1;
            end
            if (grant_reject) begin
                req_err <= arb_onehot;
                rr_ptr  <= next_idx(arb_idx);
            end

            if (state == HEADER) begin
                count <= '0;
            end else if (data_hs) begin
                count <= count + 16'd1;
            end

            if (state != DRAIN) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_SAT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (finish_ok) begin
                req_done[grant] <= 1'b1;
                rr_ptr          <= next_idx(grant);
            end
            if (finish_err) begin
                req_err[grant] <= 1'b1;
                rr_ptr         <= next_idx(grant);
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - scoreboard bench for tx_frame_arbiter
module tb_tx_frame_arbiter;
    import defines::*;

    localparam int N    = 4;
    localparam int TMO  = 40;
    localparam int K_OK = 0;
    localparam int K_REJ = 1;
    localparam int K_TMO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]        req_valid;
    address [N-1:0]      req_addr;
    byte_count_t [N-1:0] req_len;
    logic [N-1:0][7:0]   req_data;
    logic [N-1:0]        req_data_valid;
    logic [N-1:0]        req_data_ready, req_done, req_err;
    address              header_addr;
    byte_count_t         number_of_bytes;
    logic                rx_header_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                btx_full = 1'b0;
    logic                tvalid = 1'b0, tready = 1'b1, tlast = 1'b0;
    logic                busy;

    tx_frame_arbiter #(.N_REQ(N), .DRAIN_TIMEOUT(TMO), .MAX_LEN(1500)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_data        (req_data),
        .req_data_valid  (req_data_valid),
        .req_data_ready  (req_data_ready),
        .req_done        (req_done),
        .req_err         (req_err),
        .header_addr     (header_addr),
        .number_of_bytes (number_of_bytes),
        .rx_header_valid (rx_header_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .btx_full        (btx_full),
        .tx_axis_tvalid  (tvalid),
        .tx_axis_tready  (tready),
        .tx_axis_tlast   (tlast),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     port;
        int     len;
        address addr;
        int     kind;
    } rec_t;

    int checks = 0;
    int failures = 0;

    rec_t       rec_q[$];
    logic [7:0] byte_q[$];
    rec_t       cur, mon_r;
    int         frames_left[N];
    int         idx[N];
    logic [7:0] base[N];
    logic [7:0] inc[N];
    address     pa[N];
    int         plen[N];
    logic [N-1:0] hs;
    bit         in_frame = 0;
    bit         prev_beat = 0;
    bit         drain_on = 0;
    bit         bp_mode = 0;
    int         drain_cycles = 0;
    int         bytes_seen = 0;
    int         hdr_seen = 0;
    int         tmo_errs = 0;
    int         tm_rem = 0;
    int         tm_wait = 0;
    int         cyc = 0;
    logic [7:0] exp_b;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int p);
        logic [N-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    always_comb begin
        for (int p = 0; p < N; p++) begin
            req_valid[p]      = (frames_left[p] != 0);
            req_data_valid[p] = (frames_left[p] != 0);
            req_addr[p]       = pa[p];
            req_len[p]        = 16'(plen[p]);
            req_data[p]       = 8'(base[p] + inc[p] * idx[p]);
        end
    end

    // Requester sources and transmitter model advance just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int p = 0; p < N; p++) begin
                if (hs[p]) idx[p]++;
                if ((req_done[p] || req_err[p]) && frames_left[p] > 0) begin
                    frames_left[p]--;
                    idx[p] = 0;
                end
            end
            tvalid = 1'b0;
            tlast  = 1'b0;
            if (tm_wait > 0) begin
                tm_wait--;
                if (tm_wait == 0) begin
                    tvalid = 1'b1;
                    tlast  = 1'b1;
                end
            end
            cyc++;
            btx_full = bp_mode ? ((cyc % 5) < 3) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hs = '0;
        end else begin
            hs = req_data_ready & req_data_valid;
            if (drain_on && busy) drain_cycles++;
            if (in_frame) chk("ready_granted_only", req_data_ready & ~oh(cur.port), '0);
            if (tx_valid) begin
                chk("no_valid_when_full", btx_full, 1'b0);
                if (byte_q.size() == 0) begin
                    chk("extra_byte", 1'b1, 1'b0);
                end else begin
                    exp_b = byte_q.pop_front();
                    chk("tx_data", tx_data, exp_b);
                end
                bytes_seen++;
                tm_rem--;
                if (tm_rem == 0) begin
                    tm_wait      = 2;
                    drain_on     = 1;
                    drain_cycles = 0;
                end
            end
            if (rx_header_valid) begin
                hdr_seen++;
                chk("header_no_overlap", in_frame, 1'b0);
                if (rec_q.size() == 0) begin
                    chk("unexpected_header", 1'b1, 1'b0);
                end else begin
                    mon_r = rec_q.pop_front();
                    chk("header_not_reject", (mon_r.kind == K_REJ), 1'b0);
                    chk("header_addr", header_addr, mon_r.addr);
                    chk("number_of_bytes", number_of_bytes, 16'(mon_r.len));
                    cur      = mon_r;
                    in_frame = 1;
                    drain_on = 0;
                    tm_rem   = mon_r.len;
                    for (int k = 0; k < mon_r.len; k++)
                        byte_q.push_back(8'(base[mon_r.port] + inc[mon_r.port] * k));
                end
            end
            if (req_done != '0) begin
                chk("done_in_frame", in_frame, 1'b1);
                chk("done_port", req_done, oh(cur.port));
                chk("done_kind", cur.kind, K_OK);
                chk("done_after_tlast", prev_beat, 1'b1);
                chk("done_bytes_left", byte_q.size(), 0);
                chk("done_idle", busy, 1'b0);
                in_frame = 0;
                drain_on = 0;
            end
            if (req_err != '0) begin
                if (in_frame) begin
                    chk("tmo_kind", cur.kind, K_TMO);
                    chk("tmo_port", req_err, oh(cur.port));
                    chk("tmo_drain_cycles", drain_cycles, TMO);
                    chk("tmo_idle", busy, 1'b0);
                    tmo_errs++;
                    in_frame = 0;
                    drain_on = 0;
                end else if (rec_q.size() == 0) begin
                    chk("unexpected_err", 1'b1, 1'b0);
                end else begin
                    mon_r = rec_q.pop_front();
                    chk("reject_kind", mon_r.kind, K_REJ);
                    chk("reject_port", req_err, oh(mon_r.port));
                    chk("reject_idle", busy, 1'b0);
                end
            end
            prev_beat = tvalid & tready & tlast;
        end
    end

    task automatic setup_port(input int p, input int len, input address a,
                              input logic [7:0] b, input logic [7:0] s);
        plen[p] = len;
        pa[p]   = a;
        base[p] = b;
        inc[p]  = s;
    endtask

    task automatic push_rec(input int p, input int kind);
        rec_t r;
        r.port = p;
        r.len  = plen[p];
        r.addr = pa[p];
        r.kind = kind;
        rec_q.push_back(r);
    endtask

    task automatic wait_settle(input string tag, input int budget);
        int n;
        bit pending;
        n = 0;
        pending = 1;
        while (pending && n < budget) begin
            @(negedge clk);
            n++;
            pending = in_frame || (rec_q.size() != 0);
            for (int p = 0; p < N; p++) if (frames_left[p] != 0) pending = 1;
        end
        chk({"settle_", tag}, (n < budget), 1'b1);
    endtask

    function automatic address mk_addr(input logic [7:0] d, input logic [7:0] s);
        address a;
        for (int i = 0; i < 6; i++) begin
            a.dst[i] = d;
            a.src[i] = s;
        end
        return a;
    endfunction

    initial begin
        int b0, h0, n;
        for (int p = 0; p < N; p++) begin
            frames_left[p] = 0;
            idx[p]         = 0;
            setup_port(p, 4, mk_addr(8'h10 + 8'(p), 8'h20 + 8'(p)), 8'(p << 4), 8'h01);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {busy, rx_header_valid, tx_valid, req_done, req_err, req_data_ready}, '0);
        chk("reset_header_addr", header_addr, '0);
        chk("reset_nbytes", number_of_bytes, '0);
        chk("reset_tx_data", tx_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin: ports 0, 1, 3 together, port 0 twice.
        @(negedge clk);
        push_rec(0, K_OK); push_rec(1, K_OK); push_rec(3, K_OK); push_rec(0, K_OK);
        frames_left[0] = 2; frames_left[1] = 1; frames_left[3] = 1;
        wait_settle("rr", 2000);

        // Single requester, 32 bytes of 0xCC, all-0x3F header.
        setup_port(0, 32, mk_addr(8'h3F, 8'h3F), 8'hCC, 8'h00);
        b0 = bytes_seen;
        push_rec(0, K_OK);
        frames_left[0] = 1;
        wait_settle("single", 2000);
        chk("single_byte_count", bytes_seen - b0, 32);

        // Backpressure: 3 full / 2 free, bytes 0x01..0x08.
        setup_port(2, 8, mk_addr(8'hA2, 8'hB2), 8'h01, 8'h01);
        bp_mode = 1;
        b0 = bytes_seen;
        push_rec(2, K_OK);
        frames_left[2] = 1;
        wait_settle("backpressure", 2000);
        bp_mode = 0;
        chk("bp_byte_count", bytes_seen - b0, 8);

        // Rejects: zero length, then one past MAX_LEN.
        h0 = hdr_seen;
        setup_port(1, 0, mk_addr(8'h11, 8'h21), 8'h00, 8'h01);
        push_rec(1, K_REJ);
        frames_left[1] = 1;
        wait_settle("reject0", 200);
        setup_port(1, 1501, mk_addr(8'h11, 8'h21), 8'h00, 8'h01);
        push_rec(1, K_REJ);
        frames_left[1] = 1;
        wait_settle("reject1501", 200);
        chk("reject_no_header", hdr_seen - h0, 0);
        chk("reject_idle_after", busy, 1'b0);

        // Timeout on port 3, then port 0 is served once tready returns.
        setup_port(3, 2, mk_addr(8'h13, 8'h23), 8'h70, 8'h01);
        setup_port(0, 4, mk_addr(8'h10, 8'h20), 8'h90, 8'h01);
        tready = 1'b0;
        push_rec(3, K_TMO); push_rec(0, K_OK);
        frames_left[3] = 1; frames_left[0] = 1;
        n = 0;
        while (tmo_errs == 0 && n < 10 * TMO) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_seen", tmo_errs, 1);
        tready = 1'b1;
        wait_settle("after_tmo", 2000);

        // Reset in the middle of a 32-byte frame.
        setup_port(0, 32, mk_addr(8'h3F, 8'h3F), 8'h40, 8'h01);
        b0 = bytes_seen;
        push_rec(0, K_OK);
        frames_left[0] = 1;
        n = 0;
        while (bytes_seen < b0 + 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reset_reached", (bytes_seen >= b0 + 5), 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_ctrl", {busy, rx_header_valid, tx_valid, req_done, req_err, req_data_ready}, '0);
        chk("mid_reset_header", header_addr, '0);
        chk("mid_reset_nbytes", number_of_bytes, '0);
        chk("mid_reset_tx_data", tx_data, '0);
        rec_q.delete();
        byte_q.delete();
        in_frame = 0;
        drain_on = 0;
        tm_wait  = 0;
        tm_rem   = 0;
        tvalid   = 1'b0;
        tlast    = 1'b0;
        for (int p = 0; p < N; p++) begin
            frames_left[p] = 0;
            idx[p]         = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b0 = bytes_seen;
        push_rec(0, K_OK);
        frames_left[0] = 1;
        wait_settle("post_reset", 2000);
        chk("post_reset_bytes", bytes_seen - b0, 32);
        chk("final_queue_empty", rec_q.size() + byte_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
